// File: rtl/instr_fetch_queue_if.sv
// Bundle of the fetch-queue signals: redirect control, the instruction-memory
// request/response channel and the consumer-side queue head.
//
// Handshakes: imem_req_o/imem_gnt_i transfer a request when both are high on a
// rising edge. imem_rvalid_i returns one response per granted request, no
// earlier than the cycle after the grant. instr_valid_o/instr_ready_i pop the
// head when both are high on a rising edge. instr_valid_o does not depend on
// instr_ready_i.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [31:0]   imem_rdata_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;
  // Debug view of the fetch FSM: 0 = IDLE, 1 = WAIT, 2 = DROP.
  logic [1:0]    state_o;

  // Queue side.
  modport slave (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o,
           state_o
  );

  // Environment side: memory, consumer and redirect source.
  modport master (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o,
           state_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches with at most one request
// outstanding. It buffers {pc, instruction} pairs in a DEPTH-entry FIFO and
// handles redirects by flushing the FIFO and dropping any in-flight response.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_fetch_queue_if.slave    bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic issue, grant, push, pop;

  // A request reserves its FIFO slot up front, so a response can always be pushed.
  assign issue = !rst_i && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.redirect_i;
  assign grant = issue && bus.imem_gnt_i;
  assign push  = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
  assign pop   = (count_q != '0) && bus.instr_ready_i && !bus.redirect_i;

  // Next-state logic for the fetch FSM, the PCs, the FIFO pointers and the occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (bus.redirect_i) state_d = bus.imem_rvalid_i ? IDLE : DROP;
        else if (bus.imem_rvalid_i) state_d = IDLE;
      end
      // The stale response retires DROP even if another redirect arrives with it.
      // Staying in DROP there would wait for a response that never comes.
      DROP: if (bus.imem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.redirect_i) begin
      fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (grant) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers; reset abandons any outstanding request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; entries are qualified by count_q, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pend_pc_q;
      data_mem[wr_ptr_q] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_req_o    = issue;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = (count_q != '0);
  assign bus.instr_o       = (count_q != '0) ? data_mem[rd_ptr_q] : 32'h0;
  assign bus.pc_o          = (count_q != '0) ? pc_mem[rd_ptr_q]   : 32'h0;
  assign bus.count_o       = count_q;
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0).
module tb_instr_fetch_queue;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_queue_if #(.DEPTH(4)) bus ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    n_checks++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state_o); end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count_o); end
    n_checks++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid_o); end
    n_checks++; if (bus.instr_o !== 32'h0 || bus.pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_head: got instr %h pc %h want 0/0", bus.instr_o, bus.pc_o); end
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
    n_checks++; if (bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr_o); end
    rst = 1'b0;
    #1;
  endtask

  // Fill all four entries with gnt held high and rvalid one cycle after each grant.
  task automatic test_fill();
    bus.imem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'(i * 4)) begin n_fail++; $display("FAIL fill_req%0d: got req %b addr %h want 1 %h", i, bus.imem_req_o, bus.imem_addr_o, 32'(i * 4)); end
      tick();
      n_checks++; if (bus.state_o !== 2'd1 || bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL fill_wait%0d: got state %0d req %b want 1 0", i, bus.state_o, bus.imem_req_o); end
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h1000_0000 + 32'(i);
      tick();
      bus.imem_rvalid_i = 1'b0;
      #1;
    end
    n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", bus.count_o); end
    n_checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h1000_0000) begin n_fail++; $display("FAIL fill_head: got v %b pc %h instr %h want 1 0 10000000", bus.instr_valid_o, bus.pc_o, bus.instr_o); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req%0d: got %b want 0", i, bus.imem_req_o); end
      tick();
    end
  endtask

  task automatic test_pop_one();
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL pop_count: got %0d want 3", bus.count_o); end
    n_checks++; if (bus.pc_o !== 32'h4 || bus.instr_o !== 32'h1000_0001) begin n_fail++; $display("FAIL pop_head: got pc %h instr %h want 4 10000001", bus.pc_o, bus.instr_o); end
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin n_fail++; $display("FAIL pop_req: got req %b addr %h want 1 10", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_stall();
    bus.imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10 || bus.count_o !== 3'd3 || bus.state_o !== 2'd0) begin n_fail++; $display("FAIL stall%0d: got req %b addr %h cnt %0d st %0d want 1 10 3 0", i, bus.imem_req_o, bus.imem_addr_o, bus.count_o, bus.state_o); end
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    n_checks++; if (bus.state_o !== 2'd1 || bus.imem_addr_o !== 32'h14) begin n_fail++; $display("FAIL stall_grant: got st %0d addr %h want 1 14", bus.state_o, bus.imem_addr_o); end
  endtask

  task automatic test_redirect_wait();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h103;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd0 || bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got cnt %0d v %b want 0 0", bus.count_o, bus.instr_valid_o); end
    n_checks++; if (bus.state_o !== 2'd2 || bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL redir_drop: got st %0d req %b addr %h want 2 0 100", bus.state_o, bus.imem_req_o, bus.imem_addr_o); end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd0 || bus.state_o !== 2'd0) begin n_fail++; $display("FAIL redir_discard: got cnt %0d st %0d want 0 0", bus.count_o, bus.state_o); end
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL redir_req: got req %b addr %h want 1 100", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_pc_wrap();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_redir_req: got %b want 0", bus.imem_req_o); end
    tick();
    bus.redirect_i = 1'b0;
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got req %b addr %h want 1 fffffffc", bus.imem_req_o, bus.imem_addr_o); end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hCAFE_F00D;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd1 || bus.pc_o !== 32'hFFFF_FFFC || bus.instr_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wrap_entry: got cnt %0d pc %h instr %h want 1 fffffffc cafef00d", bus.count_o, bus.pc_o, bus.instr_o); end
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req %b addr %h want 1 0", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_redirect_rvalid_pop();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h2222_2222;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_gnt_i    = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd2 || bus.state_o !== 2'd1) begin n_fail++; $display("FAIL rrp_setup: got cnt %0d st %0d want 2 1", bus.count_o, bus.state_o); end
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h3333_3333;
    bus.instr_ready_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (bus.count_o !== 3'd0 || bus.state_o !== 2'd0 || bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rrp_flush: got cnt %0d st %0d v %b want 0 0 0", bus.count_o, bus.state_o, bus.instr_valid_o); end
    n_checks++; if (bus.pc_o !== 32'h0 || bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL rrp_head: got pc %h instr %h want 0 0", bus.pc_o, bus.instr_o); end
    n_checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rrp_req: got req %b addr %h want 1 200", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_idle_rvalid();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h4444_4444;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd0 || bus.state_o !== 2'd0 || bus.imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL idle_rvalid: got cnt %0d st %0d addr %h want 0 0 200", bus.count_o, bus.state_o, bus.imem_addr_o); end
  endtask

  task automatic test_back_to_back();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0000_00A0;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd1 || bus.pc_o !== 32'h200 || bus.instr_o !== 32'hA0) begin n_fail++; $display("FAIL b2b_first: got cnt %0d pc %h instr %h want 1 200 a0", bus.count_o, bus.pc_o, bus.instr_o); end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0000_00A4;
    bus.instr_ready_i = 1'b1;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd1 || bus.pc_o !== 32'h204 || bus.instr_o !== 32'hA4) begin n_fail++; $display("FAIL b2b_pushpop: got cnt %0d pc %h instr %h want 1 204 a4", bus.count_o, bus.pc_o, bus.instr_o); end
  endtask

  task automatic test_drop_redirect();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h300;
    tick();
    bus.redirect_pc_i = 32'h181;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    n_checks++; if (bus.state_o !== 2'd2 || bus.imem_addr_o !== 32'h180 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL drop_redir: got st %0d addr %h cnt %0d want 2 180 0", bus.state_o, bus.imem_addr_o, bus.count_o); end
    bus.imem_rvalid_i = 1'b1;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.state_o !== 2'd0 || bus.count_o !== 3'd0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h180) begin n_fail++; $display("FAIL drop_exit: got st %0d cnt %0d req %b addr %h want 0 0 1 180", bus.state_o, bus.count_o, bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    n_checks++; if (bus.state_o !== 2'd1) begin n_fail++; $display("FAIL rmid_wait: got st %0d want 1", bus.state_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.state_o !== 2'd0 || bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rmid_async: got st %0d req %b addr %h cnt %0d want 0 0 0 0", bus.state_o, bus.imem_req_o, bus.imem_addr_o, bus.count_o); end
    tick();
    rst = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h5555_5555;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 3'd0 || bus.state_o !== 2'd0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rmid_late_rvalid: got cnt %0d st %0d req %b addr %h want 0 0 1 0", bus.count_o, bus.state_o, bus.imem_req_o, bus.imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_one();
    test_stall();
    test_redirect_wait();
    test_pc_wrap();
    test_redirect_rvalid_pop();
    test_idle_rvalid();
    test_back_to_back();
    test_drop_redirect();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-007 SHALL have redirect_pc_i  input  32  new fetch address.
REQ-008 SHALL have imem_req_o  output  1  instruction-memory request.
REQ-009 SHALL have imem_addr_o  output  32  request address.
REQ-010 SHALL have imem_gnt_i  input  1  request accepted this cycle.
REQ-011 SHALL have imem_rvalid_i  input  1  read data valid.
REQ-012 SHALL have imem_rdata_i  input  32  read data.
REQ-013 SHALL have instr_valid_o  output  1  queue head valid.
REQ-014 SHALL have instr_o  output  32  head instruction.
REQ-015 SHALL have pc_o  output  32  head instruction address.
REQ-016 SHALL have instr_ready_i  input  1  consumer takes head.
REQ-017 SHALL have count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-019 SHALL drive imem_req_o = (state==IDLE) and (count_o<DEPTH) and not redirect_i, combinationally.
REQ-020 SHALL drive imem_addr_o from the fetch-PC register, which changes only on grant or redirect.
REQ-021 On imem_req_o and imem_gnt_i: SHALL latch fetch PC into pending-PC, add 4 to fetch PC (32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-022 If imem_req_o is high and imem_gnt_i is low, SHALL stay in IDLE and hold the same address next cycle.
REQ-023 In WAIT on imem_rvalid_i: SHALL push {pending-PC, imem_rdata_i} and go to IDLE; rvalid earliest one cycle after grant.
REQ-024 SHALL ignore imem_rvalid_i in IDLE.
REQ-025 SHALL drive instr_valid_o = (count_o!=0); instr_o/pc_o show head entry, 0 when empty.
REQ-026 SHALL pop head when instr_valid_o and instr_ready_i; push and pop in the same cycle keep count_o unchanged.
REQ-027 SHALL not overflow: issue guard of REQ-019 reserves the slot; count_o never exceeds DEPTH.
REQ-028 SHALL make pushed data visible on instr_valid_o the cycle after rvalid (one-cycle fill latency).
REQ-029 On redirect_i: SHALL clear count_o to 0 next cycle, load fetch PC with {redirect_pc_i[31:2],2'b00}, ignore same-cycle pop and push.
REQ-030 redirect_i in WAIT without rvalid SHALL go to DROP; with same-cycle rvalid SHALL discard data and go to IDLE.
REQ-031 In DROP: SHALL discard the next imem_rvalid_i and go to IDLE; a further redirect_i in DROP updates fetch PC and stays in DROP.
REQ-032 redirect_i in IDLE SHALL suppress the request that cycle and remain in IDLE.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While rst_i high: state=IDLE, fetch PC=RESET_PC, count_o=0, instr_valid_o=0, instr_o=0, pc_o=0, imem_req_o=0.
REQ-035 Reset asserted mid-transaction SHALL abandon any outstanding request; later rvalid in IDLE is ignored per REQ-024.

Verification
REQ-036 Reset release, gnt always 1, rvalid 1 cycle after gnt, ready=0 -> entries PC 0,4,8,C with their data; count_o=4; imem_req_o stays 0.
REQ-037 Full queue, ready=1 for one cycle -> pc_o 0 popped, count_o=3, new request for 32'h10 issued next cycle.
REQ-038 gnt held 0 for 3 cycles -> imem_addr_o stable at same address, no push, count_o unchanged.
REQ-039 redirect_i with redirect_pc_i=32'h103 during WAIT -> count_o=0, DROP, next rvalid discarded, next request addr 32'h100.
REQ-040 Fetch PC at 32'hFFFF_FFFC granted -> entry pc_o=32'hFFFF_FFFC, next request addr 32'h0.
REQ-041 redirect_i same cycle as rvalid and pop with count_o=2 -> data discarded, count_o=0, IDLE, request at redirect address next cycle.
